// File: rtl/sd_emmc_dma_mem_reader_if.sv
// ---------------------------------------------------------------------------
// sd_emmc_dma_mem_reader_if
// Single-beat AXI read channel (AR + R) between the SDMA memory reader and the
// system memory port.
//   master : the DMA reader (drives araddr/arvalid/rready)
//   slave  : the memory / interconnect (drives arready/rdata/rresp/rvalid/rlast)
// ---------------------------------------------------------------------------
interface sd_emmc_dma_mem_reader_if;
  logic [31:0] axi_araddr;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;
  logic        axi_rlast;

  modport master (
    output axi_araddr, axi_arvalid, axi_rready,
    input  axi_arready, axi_rdata, axi_rresp, axi_rvalid, axi_rlast
  );

  modport slave (
    input  axi_araddr, axi_arvalid, axi_rready,
    output axi_arready, axi_rdata, axi_rresp, axi_rvalid, axi_rlast
  );
endinterface

// File: rtl/sd_emmc_dma_mem_reader.sv
// ---------------------------------------------------------------------------
// sd_emmc_dma_mem_reader
// SDMA host-to-card path: reads 32-bit words from system memory with
// single-beat AXI reads (one outstanding) and pushes them into the transmit
// FIFO. Counts words per block, blocks per transfer and blocks per SDMA
// buffer boundary; stops at a boundary until the host supplies a new address.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start, abort        transfer start pulse, abort level
//   init_dma_sys_addr   start address / new address after a boundary stop
//   sys_addr_changed    host rewrote the system address (boundary resume)
//   buf_boundary        boundary = 8 << buf_boundary blocks
//   block_count, blk_count_ena  optional transfer length in blocks
//   xfer_compl          transmitter finished the last block on the line
//   dat_int_rst         clears dma_interrupts and dma_error
//   dma_interrupts      {boundary, complete}, sticky;  dma_error sticky
//   busy                not idle
//   axi                 AXI read channel (master modport)
//   fifo_wdata, fifo_we, fifo_full  transmit FIFO write port
// ---------------------------------------------------------------------------
module sd_emmc_dma_mem_reader #(
  parameter int BLK_WORDS = 128,
  parameter int BLKCNT_W  = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [31:0]             init_dma_sys_addr,
  input  logic                    sys_addr_changed,
  input  logic [2:0]              buf_boundary,
  input  logic [BLKCNT_W-1:0]     block_count,
  input  logic                    blk_count_ena,
  input  logic                    xfer_compl,
  input  logic                    dat_int_rst,
  output logic [1:0]              dma_interrupts,
  output logic                    dma_error,
  output logic                    busy,
  sd_emmc_dma_mem_reader_if.master axi,
  output logic [31:0]             fifo_wdata,
  output logic                    fifo_we,
  input  logic                    fifo_full
);

  localparam int WCNT_W = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_R, S_BLK_CHECK, S_NEW_SYS_ADDR, S_WAIT_XFER
  } state_e;

  state_e                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [10:0]           bnd_cnt_q, bnd_cnt_d;   // blocks since last boundary (max 1024)
  logic [10:0]           bound_q, bound_d;       // boundary size in blocks, sampled at start
  logic [BLKCNT_W-1:0]   tot_cnt_q, tot_cnt_d;
  logic                  ar_pend_q, ar_pend_d;   // arvalid already raised, must hold until arready
  logic                  abort_q, abort_d;       // abort seen while the read beat is outstanding
  logic [1:0]            irq_q, irq_d;
  logic                  err_q, err_d;
  logic [31:0]           fifo_wdata_q, fifo_wdata_d;
  logic                  fifo_we_q, fifo_we_d;
  logic                  ar_valid;
  logic                  r_ready;

  // rlast carries no information: every read is a single beat.
  logic unused_rlast;
  assign unused_rlast = axi.axi_rlast;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wcnt_d       = wcnt_q;
    bnd_cnt_d    = bnd_cnt_q;
    bound_d      = bound_q;
    tot_cnt_d    = tot_cnt_q;
    ar_pend_d    = ar_pend_q;
    abort_d      = abort_q;
    fifo_wdata_d = fifo_wdata_q;
    fifo_we_d    = 1'b0;
    ar_valid     = 1'b0;
    r_ready      = 1'b0;
    // Clear first so that a same-cycle set below takes priority.
    irq_d        = dat_int_rst ? 2'b00 : irq_q;
    err_d        = dat_int_rst ? 1'b0  : err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d    = init_dma_sys_addr;
          wcnt_d    = '0;
          bnd_cnt_d = '0;
          tot_cnt_d = '0;
          bound_d   = 11'd8 << buf_boundary;
          ar_pend_d = 1'b0;
          abort_d   = 1'b0;
          // A zero-length counted transfer only waits for the line to finish.
          state_d   = (blk_count_ena && block_count == '0) ? S_WAIT_XFER : S_AR;
        end
      end

      S_AR: begin
        // A new request is only issued when the FIFO has room for its word;
        // once raised it is held regardless of fifo_full.
        ar_valid = !abort && (ar_pend_q || !fifo_full);
        if (abort) begin
          ar_pend_d = 1'b0;
          state_d   = S_IDLE;
        end else if (ar_valid && axi.axi_arready) begin
          ar_pend_d = 1'b0;
          state_d   = S_R;
        end else begin
          ar_pend_d = ar_valid;
        end
      end

      S_R: begin
        r_ready = 1'b1;
        if (abort) abort_d = 1'b1;
        if (axi.axi_rvalid) begin
          abort_d = 1'b0;
          if (abort || abort_q) begin
            state_d = S_IDLE;             // drain the outstanding beat, drop its word
          end else begin
            fifo_wdata_d = axi.axi_rdata;
            fifo_we_d    = 1'b1;
            addr_d       = addr_q + 32'd4;
            if (wcnt_q == WCNT_W'(BLK_WORDS - 1)) begin
              wcnt_d  = '0;
              state_d = S_BLK_CHECK;
            end else begin
              wcnt_d  = wcnt_q + 1'b1;
              state_d = S_AR;
            end
            if (axi.axi_rresp != 2'b00) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end

      S_BLK_CHECK: begin
        tot_cnt_d = tot_cnt_q + 1'b1;
        bnd_cnt_d = bnd_cnt_q + 11'd1;
        if (abort) begin
          state_d = S_IDLE;
        end else if (blk_count_ena && tot_cnt_d == block_count) begin
          state_d = S_WAIT_XFER;
        end else if (bnd_cnt_d == bound_q) begin
          irq_d[1] = 1'b1;
          state_d  = S_NEW_SYS_ADDR;
        end else begin
          state_d = S_AR;
        end
      end

      S_NEW_SYS_ADDR: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (sys_addr_changed) begin
          addr_d    = init_dma_sys_addr;
          bnd_cnt_d = '0;
          state_d   = S_AR;
        end
      end

      S_WAIT_XFER: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer_compl) begin
          irq_d[0] = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before the edge.
  // NOTE: the data register fifo_wdata is reset as well, because its value
  // is visible on a port and must read 0 after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wcnt_q       <= '0;
      bnd_cnt_q    <= '0;
      bound_q      <= '0;
      tot_cnt_q    <= '0;
      ar_pend_q    <= 1'b0;
      abort_q      <= 1'b0;
      irq_q        <= 2'b00;
      err_q        <= 1'b0;
      fifo_wdata_q <= '0;
      fifo_we_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wcnt_q       <= wcnt_d;
      bnd_cnt_q    <= bnd_cnt_d;
      bound_q      <= bound_d;
      tot_cnt_q    <= tot_cnt_d;
      ar_pend_q    <= ar_pend_d;
      abort_q      <= abort_d;
      irq_q        <= irq_d;
      err_q        <= err_d;
      fifo_wdata_q <= fifo_wdata_d;
      fifo_we_q    <= fifo_we_d;
    end
  end

  assign axi.axi_araddr  = addr_q;
  assign axi.axi_arvalid = ar_valid;
  assign axi.axi_rready  = r_ready;
  assign fifo_wdata      = fifo_wdata_q;
  assign fifo_we         = fifo_we_q;
  assign dma_interrupts  = irq_q;
  assign dma_error       = err_q;
  assign busy            = (state_q != S_IDLE);

endmodule

// File: tb/tb_sd_emmc_dma_mem_reader.sv
// ---------------------------------------------------------------------------
// tb_sd_emmc_dma_mem_reader
// Memory-slave model plus FIFO scoreboard around sd_emmc_dma_mem_reader.
// Inputs change on the falling edge; the slave reacts 1 time unit later and
// the FIFO monitor samples 2 time units later.
// ---------------------------------------------------------------------------
module tb_sd_emmc_dma_mem_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] init_dma_sys_addr = '0;
  logic        sys_addr_changed = 1'b0;
  logic [2:0]  buf_boundary = '0;
  logic [15:0] block_count = '0;
  logic        blk_count_ena = 1'b0;
  logic        xfer_compl = 1'b0;
  logic        dat_int_rst = 1'b0;
  logic        fifo_full = 1'b0;
  logic [1:0]  dma_interrupts;
  logic        dma_error;
  logic        busy;
  logic [31:0] fifo_wdata;
  logic        fifo_we;

  sd_emmc_dma_mem_reader_if axi_if();

  sd_emmc_dma_mem_reader #(.BLK_WORDS(128), .BLKCNT_W(16)) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .abort             (abort),
    .init_dma_sys_addr (init_dma_sys_addr),
    .sys_addr_changed  (sys_addr_changed),
    .buf_boundary      (buf_boundary),
    .block_count       (block_count),
    .blk_count_ena     (blk_count_ena),
    .xfer_compl        (xfer_compl),
    .dat_int_rst       (dat_int_rst),
    .dma_interrupts    (dma_interrupts),
    .dma_error         (dma_error),
    .busy              (busy),
    .axi               (axi_if),
    .fifo_wdata        (fifo_wdata),
    .fifo_we           (fifo_we),
    .fifo_full         (fifo_full)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad = 0;
  int          rd_cnt = 0;
  int          we_cnt = 0;
  int          beat_cnt = 0;
  int          rdelay = 0;
  int          err_beat = -1;
  bit          drop_beat = 1'b0;
  bit          ar_ready_en = 1'b1;
  logic [31:0] exp_addr = '0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  bb;
    logic [15:0] cnt;
    logic        ena;
    int          reads1;     // reads before the first stop
    logic        bnd;        // boundary interrupt expected at the stop
    logic [31:0] new_addr;
    int          reads2;     // reads after resuming at new_addr
    logic        use_abort;  // end with abort instead of xfer_compl
    logic [1:0]  irq;        // final dma_interrupts
  } row_t;

  row_t rows[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5C3_3C5A;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_reads(input int n, input int budget);
    int c = 0;
    while (rd_cnt < n && c < budget) begin
      @(negedge clock);
      c++;
    end
    if (rd_cnt < n) check("wait_reads_timeout", 32'(rd_cnt), 32'(n));
  endtask

  task automatic begin_xfer(input logic [31:0] a, input logic [2:0] bb,
                            input logic [15:0] cnt, input logic ena);
    @(negedge clock);
    init_dma_sys_addr = a;
    buf_boundary      = bb;
    block_count       = cnt;
    blk_count_ena     = ena;
    exp_addr          = a;
    rd_cnt            = 0;
    we_cnt            = 0;
    beat_cnt          = 0;
    start             = 1'b1;
    @(negedge clock);
    start             = 1'b0;
  endtask

  task automatic clear_irq();
    @(negedge clock);
    dat_int_rst = 1'b1;
    @(negedge clock);
    dat_int_rst = 1'b0;
    #2;
    check("irq_cleared", 32'(dma_interrupts), 32'h0);
  endtask

  // Memory slave: single-beat reads, optional latency, error on one beat.
  initial begin
    bit          pend = 1'b0;
    bit          prev_ar = 1'b0;
    bit          prev_r = 1'b0;
    int          dly = 0;
    logic [31:0] paddr = '0;
    axi_if.axi_arready = 1'b0;
    axi_if.axi_rvalid  = 1'b0;
    axi_if.axi_rdata   = '0;
    axi_if.axi_rresp   = 2'b00;
    axi_if.axi_rlast   = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        pend = 1'b0; prev_ar = 1'b0; prev_r = 1'b0;
        axi_if.axi_rvalid  = 1'b0;
        axi_if.axi_arready = 1'b0;
        continue;
      end
      if (prev_r) begin
        axi_if.axi_rvalid = 1'b0;
        axi_if.axi_rresp  = 2'b00;
        if (drop_beat) drop_beat = 1'b0;
        else sb_q.push_back(axi_if.axi_rdata);
      end
      if (prev_ar) begin
        pend = 1'b1;
        dly  = rdelay;
      end
      if (pend) begin
        if (dly == 0) begin
          axi_if.axi_rvalid = 1'b1;
          axi_if.axi_rdata  = mem_word(paddr);
          axi_if.axi_rresp  = (beat_cnt == err_beat) ? 2'b10 : 2'b00;
          axi_if.axi_rlast  = 1'b1;
          pend = 1'b0;
          beat_cnt++;
        end else begin
          dly--;
        end
      end
      axi_if.axi_arready = ar_ready_en;
      prev_ar = axi_if.axi_arvalid && axi_if.axi_arready;
      if (prev_ar) begin
        check("araddr", axi_if.axi_araddr, exp_addr);
        exp_addr = exp_addr + 32'd4;
        paddr    = axi_if.axi_araddr;
        rd_cnt++;
      end
      prev_r = axi_if.axi_rvalid && axi_if.axi_rready;
    end
  end

  // FIFO monitor: every write strobe must carry the next expected word.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (!reset && fifo_we) begin
        we_cnt++;
        if (sb_q.size() == 0) check("fifo_we_spurious", 32'(fifo_we), 32'h0);
        else check("fifo_wdata", fifo_wdata, sb_q.pop_front());
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int hi;
    rows[0] = '{32'h1000_0000, 3'd0, 16'd1,  1'b1, 128,  1'b0, 32'h0,         0,   1'b0, 2'b01};
    rows[1] = '{32'h1000_0000, 3'd0, 16'd10, 1'b1, 1024, 1'b1, 32'h2000_0000, 256, 1'b0, 2'b11};
    rows[2] = '{32'hFFFF_FF00, 3'd1, 16'd2,  1'b1, 256,  1'b0, 32'h0,         0,   1'b0, 2'b01};
    rows[3] = '{32'h0000_4000, 3'd3, 16'd0,  1'b1, 0,    1'b0, 32'h0,         0,   1'b0, 2'b01};
    rows[4] = '{32'h0000_8000, 3'd0, 16'd3,  1'b0, 1024, 1'b1, 32'h0,         0,   1'b1, 2'b10};

    cyc(3);
    reset = 1'b0;
    #2;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_irq", 32'(dma_interrupts), 32'h0);
    check("rst_err", 32'(dma_error), 32'h0);
    check("rst_arvalid", 32'(axi_if.axi_arvalid), 32'h0);
    check("rst_rready", 32'(axi_if.axi_rready), 32'h0);
    check("rst_araddr", axi_if.axi_araddr, 32'h0);
    check("rst_fifo_we", 32'(fifo_we), 32'h0);

    // Table-driven complete transfers.
    for (int i = 0; i < 5; i++) begin
      begin_xfer(rows[i].addr, rows[i].bb, rows[i].cnt, rows[i].ena);
      wait_reads(rows[i].reads1, rows[i].reads1 * 3 + 20);
      cyc(8);
      #2;
      check("reads_phase1", 32'(rd_cnt), 32'(rows[i].reads1));
      check("bnd_irq", 32'(dma_interrupts[1]), 32'(rows[i].bnd));
      if (rows[i].bnd && !rows[i].use_abort) begin
        @(negedge clock);
        init_dma_sys_addr = rows[i].new_addr;
        exp_addr          = rows[i].new_addr;
        sys_addr_changed  = 1'b1;
        @(negedge clock);
        sys_addr_changed  = 1'b0;
        wait_reads(rows[i].reads1 + rows[i].reads2, rows[i].reads2 * 3 + 20);
        cyc(8);
        #2;
        check("reads_phase2", 32'(rd_cnt), 32'(rows[i].reads1 + rows[i].reads2));
      end
      check("busy_waiting", 32'(busy), 32'h1);
      @(negedge clock);
      if (rows[i].use_abort) abort = 1'b1;
      else xfer_compl = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      xfer_compl = 1'b0;
      cyc(1);
      #2;
      check("final_irq", 32'(dma_interrupts), 32'(rows[i].irq));
      check("final_busy", 32'(busy), 32'h0);
      check("fifo_writes", 32'(we_cnt), 32'(rows[i].reads1 + rows[i].reads2));
      check("sb_empty", 32'(sb_q.size()), 32'h0);
      clear_irq();
    end

    // FIFO full for 50 cycles mid-block: no requests issued, nothing lost.
    begin_xfer(32'h3000_0000, 3'd0, 16'd1, 1'b1);
    wait_reads(40, 200);
    fifo_full = 1'b1;
    hi = 0;
    for (int c = 0; c < 50; c++) begin
      #2;
      if (axi_if.axi_arvalid) hi++;
      @(negedge clock);
    end
    fifo_full = 1'b0;
    check("arvalid_while_full", 32'(hi), 32'h0);
    check("reads_frozen", 32'(rd_cnt), 32'd40);
    wait_reads(128, 400);
    cyc(8);
    @(negedge clock);
    xfer_compl = 1'b1;
    @(negedge clock);
    xfer_compl = 1'b0;
    #2;
    check("full_fifo_writes", 32'(we_cnt), 32'd128);
    check("full_sb_empty", 32'(sb_q.size()), 32'h0);
    check("full_irq", 32'(dma_interrupts), 32'h1);
    clear_irq();

    // Error response on word 5: word still written, error sticky, stop.
    err_beat = 5;
    begin_xfer(32'h4000_0000, 3'd0, 16'd1, 1'b1);
    wait_reads(6, 40);
    cyc(10);
    #2;
    check("err_flag", 32'(dma_error), 32'h1);
    check("err_busy", 32'(busy), 32'h0);
    check("err_reads", 32'(rd_cnt), 32'd6);
    check("err_fifo_writes", 32'(we_cnt), 32'd6);
    check("err_irq", 32'(dma_interrupts), 32'h0);
    err_beat = -1;
    @(negedge clock);
    dat_int_rst = 1'b1;
    @(negedge clock);
    dat_int_rst = 1'b0;
    #2;
    check("err_cleared", 32'(dma_error), 32'h0);

    // Abort in R with a slow beat: rready held, beat drained and dropped.
    rdelay = 7;
    begin_xfer(32'h5000_0000, 3'd0, 16'd1, 1'b1);
    wait_reads(3, 60);
    abort     = 1'b1;
    drop_beat = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    hi = 0;
    for (int c = 0; c < 4; c++) begin
      #2;
      if (axi_if.axi_rready) hi++;
      @(negedge clock);
    end
    check("abort_rready_held", 32'(hi), 32'd4);
    cyc(12);
    #2;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_irq", 32'(dma_interrupts), 32'h0);
    check("abort_fifo_writes", 32'(we_cnt), 32'd2);
    check("abort_reads", 32'(rd_cnt), 32'd3);
    check("abort_beat_taken", 32'(drop_beat), 32'h0);
    rdelay = 0;

    // Complete-interrupt set wins over a same-cycle dat_int_rst.
    begin_xfer(32'h0, 3'd0, 16'd0, 1'b1);
    cyc(3);
    xfer_compl  = 1'b1;
    dat_int_rst = 1'b1;
    @(negedge clock);
    xfer_compl  = 1'b0;
    dat_int_rst = 1'b0;
    #2;
    check("set_beats_clear", 32'(dma_interrupts), 32'h1);

    // Reset while a request is pending in AR.
    ar_ready_en = 1'b0;
    begin_xfer(32'h6000_0000, 3'd0, 16'd1, 1'b1);
    cyc(3);
    #2;
    check("ar_pending", 32'(axi_if.axi_arvalid), 32'h1);
    @(negedge clock);
    reset = 1'b1;
    cyc(2);
    #2;
    check("mid_rst_arvalid", 32'(axi_if.axi_arvalid), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_irq", 32'(dma_interrupts), 32'h0);
    check("mid_rst_err", 32'(dma_error), 32'h0);
    check("mid_rst_araddr", axi_if.axi_araddr, 32'h0);
    check("mid_rst_fifo_wdata", fifo_wdata, 32'h0);
    check("mid_rst_rready", 32'(axi_if.axi_rready), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    ar_ready_en = 1'b1;
    cyc(2);
    #2;
    check("post_rst_busy", 32'(busy), 32'h0);
    check("post_rst_arvalid", 32'(axi_if.axi_arvalid), 32'h0);
    check("post_rst_fifo_we", 32'(fifo_we), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
